// File: rtl/capture_dump_if.sv
// Bundle of the sample, command, UART and shared-RAM signals seen by capture_dump_ctrl.
// master = the controller side, slave = the surrounding sample source, UART and RAM.
interface capture_dump_if #(
  parameter int ADDR_W = 8
) ();
  logic [15:0]       sig_word;
  logic              sig_stb;
  logic [7:0]        rx_dat;
  logic              rx_valid;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_dat;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic              ram_we;
  logic [15:0]       ram_rdata;
  logic              busy;
  logic              done;

  modport master (
    input  sig_word, sig_stb, rx_dat, rx_valid, tx_busy, ram_rdata,
    output tx_start, tx_dat, ram_addr, ram_wdata, ram_we, busy, done
  );

  modport slave (
    output sig_word, sig_stb, rx_dat, rx_valid, tx_busy, ram_rdata,
    input  tx_start, tx_dat, ram_addr, ram_wdata, ram_we, busy, done
  );
endinterface

// File: rtl/capture_dump_ctrl.sv
// Captures strobed 16-bit sample words into a shared RAM and dumps them over a UART, low byte first.
// Macro CAPTURE_TRIGGER_EN adds an ARM state that skips all-0/all-1 words before capture begins.
module capture_dump_ctrl #(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] CMD_CAP = 8'h43,
  parameter logic [7:0] CMD_DMP = 8'h44,
  parameter logic [7:0] CMD_ABT = 8'h41
) (
  input  logic           clk,
  input  logic           rst,
  capture_dump_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
`ifdef CAPTURE_TRIGGER_EN
    ARM  = 4'd1,
`endif
    CAP  = 4'd2,
    RD   = 4'd3,
    RDW  = 4'd4,
    TXL  = 4'd5,
    WTL  = 4'd6,
    TXH  = 4'd7,
    WTH  = 4'd8
  } state_t;

`ifdef CAPTURE_TRIGGER_EN
  function automatic logic is_fill(input logic [15:0] w);
    return (w == 16'h0000) || (w == 16'hFFFF);
  endfunction
`endif

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              wr_vld_p1, wr_vld_nxt;
  logic [15:0]       wr_dat_p1, wr_dat_nxt;
  logic              tx_vld_p1, tx_vld_nxt;
  logic [7:0]        tx_dat_p1, tx_dat_nxt;
  logic [15:0]       held_q, held_nxt;
  logic              done_q, done_nxt;
  logic              seen_q, seen_nxt;

  logic cmd_cap, cmd_dmp, cmd_abt, last_wr;

  assign cmd_cap = bus.rx_valid && (bus.rx_dat == CMD_CAP);
  assign cmd_dmp = bus.rx_valid && (bus.rx_dat == CMD_DMP);
  assign cmd_abt = bus.rx_valid && (bus.rx_dat == CMD_ABT);
  assign last_wr = wr_vld_p1 && (addr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_vld_p1 <= 1'b0;
      wr_dat_p1 <= '0;
      tx_vld_p1 <= 1'b0;
      tx_dat_p1 <= '0;
      held_q    <= '0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      addr_q    <= addr_nxt;
      wr_vld_p1 <= wr_vld_nxt;
      wr_dat_p1 <= wr_dat_nxt;
      tx_vld_p1 <= tx_vld_nxt;
      tx_dat_p1 <= tx_dat_nxt;
      held_q    <= held_nxt;
      done_q    <= done_nxt;
      seen_q    <= seen_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    addr_nxt   = addr_q;
    wr_vld_nxt = 1'b0;
    wr_dat_nxt = wr_dat_p1;
    tx_vld_nxt = 1'b0;
    tx_dat_nxt = tx_dat_p1;
    held_nxt   = held_q;
    done_nxt   = done_q;
    seen_nxt   = seen_q;

    if (cmd_abt) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_cap) begin
            done_nxt  = 1'b0;
            addr_nxt  = '0;
`ifdef CAPTURE_TRIGGER_EN
            state_nxt = ARM;
`else
            state_nxt = CAP;
`endif
          end else if (cmd_dmp) begin
            addr_nxt  = '0;
            state_nxt = RD;
          end
        end
`ifdef CAPTURE_TRIGGER_EN
        ARM: begin
          if (bus.sig_stb && !is_fill(bus.sig_word)) begin
            wr_vld_nxt = 1'b1;
            wr_dat_nxt = bus.sig_word;
            state_nxt  = CAP;
          end
        end
`endif
        CAP: begin
          // The write issued last cycle lands at addr_q; advance past it, finish after the top word.
          if (wr_vld_p1) begin
            addr_nxt = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
          if (bus.sig_stb && !last_wr) begin
            wr_vld_nxt = 1'b1;
            wr_dat_nxt = bus.sig_word;
          end
        end
        RD:  state_nxt = RDW;
        RDW: begin
          held_nxt  = bus.ram_rdata;
          state_nxt = TXL;
        end
        TXL: begin
          if (!bus.tx_busy) begin
            tx_vld_nxt = 1'b1;
            tx_dat_nxt = held_q[7:0];
            seen_nxt   = 1'b0;
            state_nxt  = WTL;
          end
        end
        WTL: begin
          // tx_busy in the tx_start cycle may be stale from the previous byte.
          if (!tx_vld_p1) begin
            if (bus.tx_busy)  seen_nxt  = 1'b1;
            else if (seen_q)  state_nxt = TXH;
          end
        end
        TXH: begin
          if (!bus.tx_busy) begin
            tx_vld_nxt = 1'b1;
            tx_dat_nxt = held_q[15:8];
            seen_nxt   = 1'b0;
            state_nxt  = WTH;
          end
        end
        WTH: begin
          if (!tx_vld_p1) begin
            if (bus.tx_busy) begin
              seen_nxt = 1'b1;
            end else if (seen_q) begin
              addr_nxt  = addr_q + 1'b1;
              state_nxt = (addr_q == LAST_ADDR) ? IDLE : RD;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wr_dat_p1;
  assign bus.ram_we    = wr_vld_p1;
  assign bus.tx_start  = tx_vld_p1;
  assign bus.tx_dat    = tx_dat_p1;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Directed bench for capture_dump_ctrl: vector table plus hand-written capture, dump, abort and reset sequences.
// Shared RAM and a UART (busy for 10 cycles after each tx_start) are modelled here.
module tb_capture_dump_ctrl;
  localparam logic [7:0] C_CAP = 8'h43;
  localparam logic [7:0] C_DMP = 8'h44;
  localparam logic [7:0] C_ABT = 8'h41;
  localparam int NV = 15;

  logic clk;
  logic rst;
  capture_dump_if #(.ADDR_W(8)) bus ();

  capture_dump_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int ucnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst)                ucnt <= 0;
    else if (bus.tx_start)   ucnt <= 10;
    else if (ucnt != 0)      ucnt <= ucnt - 1;
  end
  assign bus.tx_busy = (ucnt != 0);

  int we_total = 0;
  int ts_total = 0;
  int bad_evt  = 0;
  logic [7:0] tx_log [0:2047];
  always @(posedge clk) begin
    if (bus.ram_we) we_total <= we_total + 1;
    if (bus.tx_start) begin
      tx_log[ts_total[10:0]] <= bus.tx_dat;
      ts_total <= ts_total + 1;
    end
    if ((bus.ram_we && bus.tx_start) || (bus.ram_we && !bus.busy)) bad_evt <= bad_evt + 1;
  end
  always @(negedge clk) begin
    if (!rst && (bus.ram_we || bus.tx_start)) bad_evt <= bad_evt + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dat   = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_dat   = 8'h00;
  endtask

  task automatic strobe(input logic [15:0] w);
    @(negedge clk);
    bus.sig_word = w;
    bus.sig_stb  = 1'b1;
    @(negedge clk);
    bus.sig_stb  = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input string name);
    int guard;
    guard = 0;
    while (ts_total < target && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check(name, 32'(guard < 300), 32'd1);
  endtask

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        stb;
    logic [15:0] word;
    logic        busy;
    logic        done;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        ts;
    logic [7:0]  txd;
  } vec_t;

  vec_t tv [NV];

  initial begin
    int guard, bad, base_we, base_ts, idx, got, fidx;
    logic [7:0]  eb;
    logic [15:0] fw, ew;
    logic [7:0]  fa;
    logic [15:0] tw [3];

    tv[0]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    tv[1]  = '{1'b1, 8'h58, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    tv[3]  = '{1'b1, 8'h43, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1, 8'h00, 16'hABCD, 1'b0, 8'h00};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h01, 16'hABCD, 1'b0, 8'h00};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 8'h01, 16'h5555, 1'b0, 8'h00};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 16'h6666, 1'b1, 1'b0, 1'b1, 8'h02, 16'h6666, 1'b0, 8'h00};
    tv[8]  = '{1'b1, 8'h44, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h03, 16'h6666, 1'b0, 8'h00};
    tv[9]  = '{1'b1, 8'h41, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 8'h03, 16'h6666, 1'b0, 8'h00};
    tv[10] = '{1'b1, 8'h44, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h6666, 1'b0, 8'h00};
    tv[11] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h6666, 1'b0, 8'h00};
    tv[12] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h6666, 1'b0, 8'h00};
    tv[13] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h6666, 1'b1, 8'hCD};
    tv[14] = '{1'b1, 8'h41, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h6666, 1'b0, 8'hCD};

    rst = 1'b0;
    bus.sig_word = 16'h0000;
    bus.sig_stb  = 1'b0;
    bus.rx_dat   = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_we",    32'(bus.ram_we),    32'd0);
    check("rst_ts",    32'(bus.tx_start),  32'd0);
    check("rst_addr",  32'(bus.ram_addr),  32'd0);
    check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_txd",   32'(bus.tx_dat),    32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.rx_valid = tv[i].rxv;
      bus.rx_dat   = tv[i].rxd;
      bus.sig_stb  = tv[i].stb;
      bus.sig_word = tv[i].word;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busy", i),  32'(bus.busy),      32'(tv[i].busy));
      check($sformatf("v%0d_done", i),  32'(bus.done),      32'(tv[i].done));
      check($sformatf("v%0d_we", i),    32'(bus.ram_we),    32'(tv[i].we));
      check($sformatf("v%0d_addr", i),  32'(bus.ram_addr),  32'(tv[i].addr));
      check($sformatf("v%0d_wdata", i), 32'(bus.ram_wdata), 32'(tv[i].wdata));
      check($sformatf("v%0d_ts", i),    32'(bus.tx_start),  32'(tv[i].ts));
      check($sformatf("v%0d_txd", i),   32'(bus.tx_dat),    32'(tv[i].txd));
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.sig_stb  = 1'b0;
    repeat (15) @(negedge clk);

    // full 256-word capture
    send_cmd(C_CAP);
    base_we = we_total;
    for (int n = 0; n < 256; n++) strobe(16'h1000 + n[15:0]);
    repeat (2) @(negedge clk);
    check("cap_done",     32'(bus.done),     32'd1);
    check("cap_busy",     32'(bus.busy),     32'd0);
    check("cap_addr",     32'(bus.ram_addr), 32'd0);
    check("cap_we_count", 32'(we_total - base_we), 32'd256);
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[n[7:0]] !== 16'h1000 + n[15:0]) bad++;
    check("cap_ram_bad_words", 32'(bad), 32'd0);
    strobe(16'h9999);
    repeat (2) @(negedge clk);
    check("cap_no_extra_write", 32'(we_total - base_we), 32'd256);

    // full dump
    base_ts = ts_total;
    send_cmd(C_DMP);
    check("dump_busy", 32'(bus.busy), 32'd1);
    guard = 0;
    while (bus.busy && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("dump_in_time", 32'(guard < 20000), 32'd1);
    check("dump_bytes",   32'(ts_total - base_ts), 32'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      idx = base_ts + i;
      eb  = (i % 2 == 0) ? 8'(i / 2) : 8'h10;
      if (tx_log[idx[10:0]] !== eb) bad++;
    end
    check("dump_bad_bytes", 32'(bad), 32'd0);
    check("dump_done_kept", 32'(bus.done), 32'd1);
    check("dump_addr_wrap", 32'(bus.ram_addr), 32'd0);
    repeat (15) @(negedge clk);

    // abort after three dump bytes
    base_ts = ts_total;
    send_cmd(C_DMP);
    wait_bytes(base_ts + 3, "abort_wait_3_bytes");
    bus.rx_dat   = C_ABT;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy),     32'd0);
    check("abort_done", 32'(bus.done),     32'd1);
    check("abort_ts",   32'(bus.tx_start), 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_dat   = 8'h00;
    repeat (60) @(negedge clk);
    check("abort_no_more_bytes", 32'(ts_total - base_ts), 32'd3);
    check("abort_idle", 32'(bus.busy), 32'd0);

    // reset in the middle of a capture at address 0x40
    send_cmd(C_CAP);
    for (int n = 0; n < 64; n++) strobe(16'h2000 + n[15:0]);
    @(negedge clk);
    check("mid_cap_addr", 32'(bus.ram_addr), 32'h40);
    check("mid_cap_busy", 32'(bus.busy),     32'd1);
    bus.sig_word = 16'h2040;
    bus.sig_stb  = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_busy",  32'(bus.busy),      32'd0);
    check("arst_addr",  32'(bus.ram_addr),  32'd0);
    check("arst_we",    32'(bus.ram_we),    32'd0);
    check("arst_wdata", 32'(bus.ram_wdata), 32'd0);
    check("arst_txd",   32'(bus.tx_dat),    32'd0);
    check("arst_done",  32'(bus.done),      32'd0);
    base_we = we_total;
    base_ts = ts_total;
    repeat (3) @(negedge clk);
    bus.sig_stb = 1'b0;
    check("arst_no_write", 32'(we_total - base_we), 32'd0);
    check("arst_no_tx",    32'(ts_total - base_ts), 32'd0);
    rst = 1'b1;
    send_cmd(C_DMP);
    wait_bytes(base_ts + 2, "post_rst_wait_bytes");
    idx = base_ts;
    check("post_rst_byte0", 32'(tx_log[idx[10:0]]), 32'h00);
    idx = base_ts + 1;
    check("post_rst_byte1", 32'(tx_log[idx[10:0]]), 32'h20);
    send_cmd(C_ABT);
    repeat (15) @(negedge clk);

    // trigger words at the start of a capture
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_cmd(C_CAP);
    check("trig_busy", 32'(bus.busy), 32'd1);
    tw[0] = 16'h0000;
    tw[1] = 16'hFFFF;
    tw[2] = 16'h00F0;
    got = 0; fidx = -1; fw = 16'h0000; fa = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.sig_word = tw[k];
      bus.sig_stb  = 1'b1;
      @(posedge clk);
      #1;
      if (bus.ram_we && got == 0) begin
        got  = 1;
        fidx = k;
        fw   = bus.ram_wdata;
        fa   = bus.ram_addr;
      end
      @(negedge clk);
      bus.sig_stb = 1'b0;
    end
`ifdef CAPTURE_TRIGGER_EN
    ew = 16'h00F0;
    check("trig_first_idx", 32'(fidx), 32'd2);
`else
    ew = 16'h0000;
    check("trig_first_idx", 32'(fidx), 32'd0);
`endif
    check("trig_first_data", 32'(fw), 32'(ew));
    check("trig_first_addr", 32'(fa), 32'd0);
    send_cmd(C_ABT);
    check("trig_abort_idle", 32'(bus.busy), 32'd0);

    check("no_we_ts_overlap_or_stray", 32'(bad_evt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
